// File: rtl/arm_dp_operand_stage.sv
// rtl/arm_dp_operand_stage.sv - ARM data-processing operand preparation stage
//
// Reads Rn, Rm and optionally Rs through one register-file read port (one
// register per cycle), applies the rotated immediate or barrel shift, and
// presents ALU operands plus write-back control under a valid/ready handshake.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   instr_valid/instr_ready     upstream instruction handshake
//   instr[31:0]                 instruction word (condition already passed)
//   rf_rd_addr[3:0]             registered register-file read address
//   rf_rd_data[31:0]            combinational read data for rf_rd_addr
//   cpsr_prev[31:0]             current CPSR, bit 29 is the C flag
//   op_valid/op_ready           downstream operand handshake
//   alu_op1, alu_op2            Rn value and shifted second operand
//   alu_op_sel                  opcode instr[24:21]
//   shifter_carry               barrel-shifter carry-out
//   set_flags, rd_addr, wb_en   write-back control (wb_en=0 for TST/TEQ/CMP/CMN)

module arm_dp_operand_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [3:0]  rf_rd_addr,
  input  logic [31:0] rf_rd_data,
  input  logic [31:0] cpsr_prev,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [3:0]  alu_op_sel,
  output logic        shifter_carry,
  output logic        set_flags,
  output logic [3:0]  rd_addr,
  output logic        wb_en
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_RN = 3'd1,
    RD_RM = 3'd2,
    RD_RS = 3'd3,
    OUT   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        imm_q;     // latched I bit
  logic [11:0] fld_q;     // latched operand-2 field
  logic [31:0] rm_q;      // Rm held while Rs is read
  logic        c_flag;
  logic        accept;
  logic        unused_bits;

  assign c_flag      = cpsr_prev[29];
  assign instr_ready = (state_q == IDLE) && rst_n;
  assign op_valid    = (state_q == OUT);
  assign accept      = instr_valid && instr_ready;
  assign unused_bits = ^{cpsr_prev[31:30], cpsr_prev[28:0], instr[31:28]};

  // Shift by a non-zero amount (1..31). Returns {carry, result}; carry is the
  // last bit shifted out (for ROR, the new bit 31).
  function automatic logic [32:0] shift_nz(input logic [31:0] v,
                                           input logic [1:0]  typ,
                                           input logic [4:0]  a);
    logic [32:0] t;
    logic [31:0] r;
    logic [5:0]  inv;
    inv = 6'd32 - {1'b0, a};
    r   = (v >> a) | (v << inv);
    case (typ)
      2'b00:   t = {1'b0, v} << a;
      2'b01:   begin
        t = {v, 1'b0} >> a;
        t = {t[0], t[32:1]};
      end
      2'b10:   begin
        t = $unsigned($signed({v, 1'b0}) >>> a);
        t = {t[0], t[32:1]};
      end
      default: t = {r[31], r};
    endcase
    return t;
  endfunction

  // Rotated 8-bit immediate; a zero rotation leaves the carry flag untouched.
  function automatic logic [32:0] imm_operand(input logic [11:0] f,
                                              input logic        c);
    if (f[11:8] == 4'd0)
      return {c, 24'd0, f[7:0]};
    return shift_nz({24'd0, f[7:0]}, 2'b11, {f[11:8], 1'b0});
  endfunction

  // Immediate-amount shift; amount 0 encodes LSR/ASR #32 and RRX.
  function automatic logic [32:0] imm_shift(input logic [31:0] v,
                                            input logic [1:0]  typ,
                                            input logic [4:0]  a,
                                            input logic        c);
    if (a != 5'd0)
      return shift_nz(v, typ, a);
    case (typ)
      2'b00:   return {c, v};
      2'b01:   return {v[31], 32'd0};
      2'b10:   return {v[31], {32{v[31]}}};
      default: return {v[0], c, v[31:1]};
    endcase
  endfunction

  // Register-amount shift using the full 8-bit amount from Rs.
  function automatic logic [32:0] reg_shift(input logic [31:0] v,
                                            input logic [1:0]  typ,
                                            input logic [7:0]  s,
                                            input logic        c);
    if (s == 8'd0)
      return {c, v};
    case (typ)
      2'b00: begin
        if (s < 8'd32)       return shift_nz(v, 2'b00, s[4:0]);
        else if (s == 8'd32) return {v[0], 32'd0};
        else                 return 33'd0;
      end
      2'b01: begin
        if (s < 8'd32)       return shift_nz(v, 2'b01, s[4:0]);
        else if (s == 8'd32) return {v[31], 32'd0};
        else                 return 33'd0;
      end
      2'b10: begin
        if (s < 8'd32)       return shift_nz(v, 2'b10, s[4:0]);
        else                 return {v[31], {32{v[31]}}};
      end
      default: begin
        // Multiples of 32 rotate back to Rm with carry = Rm[31].
        if (s[4:0] == 5'd0)  return {v[31], v};
        else                 return shift_nz(v, 2'b11, s[4:0]);
      end
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && instr[27:26] == 2'b00) state_d = RD_RN;
      RD_RN:   state_d = imm_q ? OUT : RD_RM;
      RD_RM:   state_d = fld_q[4] ? RD_RS : OUT;
      RD_RS:   state_d = OUT;
      OUT:     if (op_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      imm_q         <= 1'b0;
      fld_q         <= 12'd0;
      rm_q          <= 32'd0;
      rf_rd_addr    <= 4'd0;
      alu_op1       <= 32'd0;
      alu_op2       <= 32'd0;
      shifter_carry <= 1'b0;
      alu_op_sel    <= 4'd0;
      set_flags     <= 1'b0;
      rd_addr       <= 4'd0;
      wb_en         <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          // Non data-processing encodings are accepted and dropped.
          if (accept && instr[27:26] == 2'b00) begin
            imm_q      <= instr[25];
            fld_q      <= instr[11:0];
            rf_rd_addr <= instr[19:16];
            alu_op_sel <= instr[24:21];
            set_flags  <= instr[20];
            rd_addr    <= instr[15:12];
            wb_en      <= (instr[24:23] != 2'b10);
          end
        end
        RD_RN: begin
          alu_op1 <= rf_rd_data;
          if (imm_q)
            {shifter_carry, alu_op2} <= imm_operand(fld_q, c_flag);
          else
            rf_rd_addr <= fld_q[3:0];
        end
        RD_RM: begin
          rm_q <= rf_rd_data;
          if (fld_q[4])
            rf_rd_addr <= fld_q[11:8];
          else
            {shifter_carry, alu_op2} <= imm_shift(rf_rd_data, fld_q[6:5],
                                                  fld_q[11:7], c_flag);
        end
        RD_RS: begin
          {shifter_carry, alu_op2} <= reg_shift(rm_q, fld_q[6:5],
                                                rf_rd_data[7:0], c_flag);
        end
        default: ;
      endcase
    end
  end

endmodule
